ps2_frame_receiver: RTL

- Upstream front end for the pipelined processor's keyboard inputs.
- Oversamples raw PS/2 clock/data lines in the system clock domain and deframes 11-bit PS/2 frames: start 0, 8 data bits LSB first, odd parity, stop 1.
- Drives ps2_out and a one-cycle ps2_key_pressed strobe straight into the processor.
- Checks parity, stop bit and inter-edge timeout; optionally swallows break (key-release) sequences.

---
 rtl/ps2_pkg.sv | 14 +
 rtl/ps2_frame_receiver_if.sv | 23 ++
 rtl/ps2_line_sync.sv | 35 +++
 rtl/ps2_frame_receiver.sv | 135 +++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 frame receiver.
package ps2_pkg;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_e;

  localparam int unsigned DATA_BITS  = 8;
  localparam logic [7:0]  BREAK_CODE = 8'hF0;

  // Odd parity holds when the data bits plus the parity bit contain an odd number of ones.
  function automatic logic odd_parity_ok(logic [DATA_BITS-1:0] data, logic parity);
    return ^data ^ parity;
  endfunction

endpackage

// File: rtl/ps2_frame_receiver_if.sv
// Raw PS/2 lines in, received byte strobes and error pulses out.
interface ps2_frame_receiver_if;
  import ps2_pkg::*;

  logic                 ps2_clock;
  logic                 ps2_data;
  logic                 ps2_key_pressed;
  logic [DATA_BITS-1:0] ps2_out;
  logic                 parity_error;
  logic                 frame_error;
  logic                 busy;

  modport master (
    output ps2_clock, ps2_data,
    input  ps2_key_pressed, ps2_out, parity_error, frame_error, busy
  );

  modport slave (
    input  ps2_clock, ps2_data,
    output ps2_key_pressed, ps2_out, parity_error, frame_error, busy
  );

endinterface

// File: rtl/ps2_line_sync.sv
// Synchronizes the raw PS/2 clock/data lines and flags PS/2 clock falling edges.
module ps2_line_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic ps2_clock,
  input  logic ps2_data,
  output logic clk_s,
  output logic data_s,
  output logic fall
);

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   clk_prev;

  // Preset to 1 so an idle bus right after reset is not seen as an edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clock};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
      clk_prev  <= clk_sync[SYNC_STAGES-1];
    end
  end

  assign clk_s  = clk_sync[SYNC_STAGES-1];
  assign data_s = data_sync[SYNC_STAGES-1];
  assign fall   = clk_prev & ~clk_s;

endmodule

// File: rtl/ps2_frame_receiver.sv
// Deframes 11-bit PS/2 frames, checks parity/stop/timeout and optionally swallows break codes.
module ps2_frame_receiver
  import ps2_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 5000,
  parameter bit          FILTER_BREAK   = 1'b1
) (
  input logic                  clock,
  input logic                  reset,
  ps2_frame_receiver_if.slave  bus
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic clk_s, data_s, fall;

  ps2_line_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_line_sync (
    .clock    (clock),
    .reset    (reset),
    .ps2_clock(bus.ps2_clock),
    .ps2_data (bus.ps2_data),
    .clk_s    (clk_s),
    .data_s   (data_s),
    .fall     (fall)
  );

  state_e               state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic                 parity_q, parity_d;
  logic [TW-1:0]        tmo_q, tmo_d;
  logic                 break_q, break_d;
  logic [DATA_BITS-1:0] out_q, out_d;
  logic                 strobe_q, strobe_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 timeout;

  assign timeout = (state_q != IDLE) && (tmo_q == TW'(TIMEOUT_CYCLES));

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    parity_d  = parity_q;
    break_d   = break_q;
    out_d     = out_q;
    strobe_d  = 1'b0;
    perr_d    = 1'b0;
    ferr_d    = 1'b0;

    if (state_q == IDLE || fall) begin
      tmo_d = '0;
    end else if (!timeout) begin
      tmo_d = tmo_q + 1'b1;
    end else begin
      tmo_d = tmo_q;
    end

    // Timeout beats a coincident edge: the partial frame is dropped.
    if (timeout) begin
      state_d = IDLE;
      ferr_d  = 1'b1;
    end else if (fall) begin
      unique case (state_q)
        IDLE: begin
          if (!data_s) begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end
        end
        DATA: begin
          shift_d[bit_cnt_q] = data_s;
          bit_cnt_d          = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'(DATA_BITS - 1)) state_d = PARITY;
        end
        PARITY: begin
          parity_d = data_s;
          state_d  = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (!data_s) begin
            ferr_d = 1'b1;
          end else if (!odd_parity_ok(shift_q, parity_q)) begin
            perr_d = 1'b1;
          end else if (FILTER_BREAK && shift_q == BREAK_CODE) begin
            break_d = 1'b1;
          end else if (FILTER_BREAK && break_q) begin
            break_d = 1'b0;
          end else begin
            out_d    = shift_q;
            strobe_d = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      parity_q  <= 1'b0;
      tmo_q     <= '0;
      break_q   <= 1'b0;
      out_q     <= '0;
      strobe_q  <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      parity_q  <= parity_d;
      tmo_q     <= tmo_d;
      break_q   <= break_d;
      out_q     <= out_d;
      strobe_q  <= strobe_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
    end
  end

  assign bus.ps2_key_pressed = strobe_q;
  assign bus.ps2_out         = out_q;
  assign bus.parity_error    = perr_q;
  assign bus.frame_error     = ferr_q;
  assign bus.busy            = (state_q != IDLE);

endmodule
